// File: rtl/icache_dm_if.sv
// Fetch-side and ROM-side signal bundle for the direct-mapped instruction cache.
// The slave modport is the cache; the master modport is the core plus ROM.
interface icache_dm_if;
  logic        if_req;
  logic [63:0] if_addr;
  logic [31:0] if_dout;
  logic        if_ready;
  logic        flush;
  logic [63:0] rom_addr;
  logic [31:0] rom_dout;
  logic [31:0] perf_hits;
  logic [31:0] perf_misses;

  modport master (
    output if_req, if_addr, flush, rom_dout,
    input  if_dout, if_ready, rom_addr, perf_hits, perf_misses
  );

  modport slave (
    input  if_req, if_addr, flush, rom_dout,
    output if_dout, if_ready, rom_addr, perf_hits, perf_misses
  );
endinterface

// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache. Hits return in the request cycle;
// misses stream a full line from a synchronous ROM through a two-state refill FSM.
module icache_dm #(
  parameter int LINE_WORDS  = 4,
  parameter int NUM_LINES   = 64,
  parameter int ROM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  icache_dm_if.slave  bus
);
  localparam int OFF_W      = $clog2(LINE_WORDS);
  localparam int IDX_W      = $clog2(NUM_LINES);
  localparam int TAG_W      = 64 - 2 - OFF_W - IDX_W;
  localparam int REFILL_CYC = LINE_WORDS + ROM_LATENCY;
  localparam int CNT_W      = $clog2(REFILL_CYC + 1);

  typedef enum logic {IDLE, REFILL} state_t;

  state_t                 state;
  logic [NUM_LINES-1:0]   valid;
  logic [TAG_W-1:0]       tag_mem  [NUM_LINES];
  logic [31:0]            data_mem [NUM_LINES][LINE_WORDS];
  logic [CNT_W-1:0]       cnt;
  logic [63:OFF_W+2]      line_base;
  logic [31:0]            hit_cnt, miss_cnt;

  logic [OFF_W-1:0]       req_off;
  logic [IDX_W-1:0]       req_idx, ref_idx;
  logic [TAG_W-1:0]       req_tag;
  logic [OFF_W-1:0]       word_off;
  logic [CNT_W-1:0]       wr_pos;
  logic                   hit, rdy, miss_start, refill_wr;
  logic [63:0]            rom_addr_c;
  logic                   unused_addr_bits;

  assign req_off  = bus.if_addr[2 +: OFF_W];
  assign req_idx  = bus.if_addr[OFF_W+2 +: IDX_W];
  assign req_tag  = bus.if_addr[63 -: TAG_W];
  assign ref_idx  = line_base[OFF_W+2 +: IDX_W];
  assign unused_addr_bits = ^bus.if_addr[1:0];

  assign hit        = valid[req_idx] && (tag_mem[req_idx] == req_tag);
  assign rdy        = (state == IDLE) && bus.if_req && hit && !bus.flush;
  assign miss_start = (state == IDLE) && bus.if_req && !hit && !bus.flush;

  // Address keeps issuing the last word while the ROM pipeline drains.
  assign word_off  = (cnt < CNT_W'(LINE_WORDS)) ? cnt[OFF_W-1:0] : '1;
  assign wr_pos    = cnt - CNT_W'(ROM_LATENCY);
  assign refill_wr = (state == REFILL) && !bus.flush && (cnt >= CNT_W'(ROM_LATENCY));

  always_comb begin
    rom_addr_c = '0;
    if (rst)                  rom_addr_c = '0;
    else if (state == REFILL) rom_addr_c = {line_base, word_off, 2'b00};
    else                      rom_addr_c = {bus.if_addr[63:2], 2'b00};
  end

  assign bus.rom_addr    = rom_addr_c;
  assign bus.if_ready    = rdy;
  assign bus.if_dout     = rdy ? data_mem[req_idx][req_off] : '0;
  assign bus.perf_hits   = hit_cnt;
  assign bus.perf_misses = miss_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      valid     <= '0;
      cnt       <= '0;
      line_base <= '0;
      hit_cnt   <= '0;
      miss_cnt  <= '0;
    end else if (bus.flush) begin
      // An aborted refill leaves its line invalid, so no partial data is ever hit.
      valid <= '0;
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (rdy && hit_cnt != '1) hit_cnt <= hit_cnt + 32'd1;
          if (miss_start) begin
            line_base      <= bus.if_addr[63:OFF_W+2];
            valid[req_idx] <= 1'b0;
            cnt            <= '0;
            state          <= REFILL;
            if (miss_cnt != '1) miss_cnt <= miss_cnt + 32'd1;
          end
        end
        REFILL: begin
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(REFILL_CYC - 1)) begin
            valid[ref_idx] <= 1'b1;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Tag and data arrays carry no reset; valid alone gates their use.
  always_ff @(posedge clk) begin
    if (miss_start) tag_mem[req_idx] <= req_tag;
    if (refill_wr)  data_mem[ref_idx][wr_pos[OFF_W-1:0]] <= bus.rom_dout;
  end
endmodule

// File: tb/tb_icache_dm.sv
// Self-checking bench for icache_dm: directed scenarios plus a randomized fetch
// stream checked against a line-number based cache model and a hashed ROM.
module tb_icache_dm;
  localparam int LW  = 4;
  localparam int NL  = 64;
  localparam int RL  = 1;
  localparam int PEN = LW + RL + 1;
  localparam int OFFB = $clog2(LW) + 2;

  logic clk = 1'b0;
  logic rst;
  icache_dm_if bus();

  icache_dm #(.LINE_WORDS(LW), .NUM_LINES(NL), .ROM_LATENCY(RL)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  function automatic logic [31:0] rom_word(input logic [63:0] a);
    logic [31:0] w;
    w = a[33:2];
    return (w * 32'h9E37_79B1) ^ a[63:32] ^ 32'h5A5A_1234;
  endfunction

  logic [31:0] rom_pipe [RL];
  always @(posedge clk) begin
    rom_pipe[0] <= rom_word(bus.rom_addr);
    for (int i = 1; i < RL; i++) rom_pipe[i] <= rom_pipe[i-1];
  end
  assign bus.rom_dout = rom_pipe[RL-1];

  // Reference model: which memory line (address / line bytes) each slot holds.
  bit              m_valid [NL];
  longint unsigned m_line  [NL];
  logic [31:0]     m_hits, m_misses;

  function automatic void m_flush();
    for (int i = 0; i < NL; i++) m_valid[i] = 1'b0;
  endfunction

  function automatic void m_reset();
    m_flush();
    m_hits = 0;
    m_misses = 0;
  endfunction

  function automatic void m_count_hit();
    if (m_hits != 32'hFFFF_FFFF) m_hits = m_hits + 1;
  endfunction

  function automatic void m_count_miss();
    if (m_misses != 32'hFFFF_FFFF) m_misses = m_misses + 1;
  endfunction

  // Returns the expected cycles of if_ready=0 before the returning hit.
  function automatic int model_fetch(input logic [63:0] a);
    longint unsigned ln;
    int idx;
    ln  = longint'(a) >> OFFB;
    idx = int'(ln % NL);
    if (m_valid[idx] && m_line[idx] == ln) begin
      m_count_hit();
      return 0;
    end
    m_valid[idx] = 1'b1;
    m_line[idx]  = ln;
    m_count_miss();
    m_count_hit();
    return PEN;
  endfunction

  task automatic fetch(input logic [63:0] a, output int lat, output logic [31:0] d);
    bus.if_req  = 1'b1;
    bus.if_addr = a;
    lat = 0;
    d   = '0;
    while (1) begin
      @(negedge clk);
      if (bus.if_ready) begin
        d = bus.if_dout;
        break;
      end
      lat++;
      if (lat > 40) begin
        checks++; errors++;
        $display("FAIL fetch_timeout addr=%h waited=%0d cycles need<=%0d", a, lat, PEN);
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    bus.if_req = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.if_req  = 1'b1;
    bus.if_addr = {$urandom, $urandom};
    repeat (2) @(negedge clk);
    checks++; if (bus.if_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b want=0", bus.if_ready); end
    checks++; if (bus.if_dout !== 32'h0) begin errors++; $display("FAIL reset_dout got=%h want=0", bus.if_dout); end
    checks++; if (bus.rom_addr !== 64'h0) begin errors++; $display("FAIL reset_rom_addr got=%h want=0", bus.rom_addr); end
    checks++; if (bus.perf_hits !== 32'h0) begin errors++; $display("FAIL reset_hits got=%0d want=0", bus.perf_hits); end
    checks++; if (bus.perf_misses !== 32'h0) begin errors++; $display("FAIL reset_misses got=%0d want=0", bus.perf_misses); end
    rst = 1'b0;
    bus.if_req = 1'b0;
    m_reset();
    @(posedge clk); #1;
  endtask

  task automatic test_first_miss();
    int not_ready;
    logic [31:0] d6;
    logic rdy6;
    not_ready = 0;
    d6 = '0;
    rdy6 = 1'b0;
    bus.if_req  = 1'b1;
    bus.if_addr = 64'h0;
    for (int cyc = 0; cyc <= 6; cyc++) begin
      @(negedge clk);
      if (cyc < 6 && !bus.if_ready) not_ready++;
      if (cyc >= 1 && cyc <= 4) begin
        checks++;
        if (bus.rom_addr !== 64'(4 * (cyc - 1))) begin
          errors++; $display("FAIL miss_rom_addr cyc=%0d got=%h want=%h", cyc, bus.rom_addr, 4 * (cyc - 1));
        end
      end
      if (cyc == 6) begin rdy6 = bus.if_ready; d6 = bus.if_dout; end
      @(posedge clk); #1;
    end
    bus.if_req = 1'b0;
    void'(model_fetch(64'h0));
    checks++; if (not_ready != 6) begin errors++; $display("FAIL miss_stall got=%0d want=6 stalled cycles", not_ready); end
    checks++; if (rdy6 !== 1'b1) begin errors++; $display("FAIL miss_ready6 got=%b want=1", rdy6); end
    checks++; if (d6 !== rom_word(64'h0)) begin errors++; $display("FAIL miss_data got=%h want=%h", d6, rom_word(64'h0)); end
    checks++; if (bus.perf_misses !== 32'd1) begin errors++; $display("FAIL miss_count got=%0d want=1", bus.perf_misses); end
  endtask

  task automatic test_line_hits();
    int lat, exp_lat;
    logic [31:0] d;
    for (int i = 1; i < 4; i++) begin
      exp_lat = model_fetch(64'(4 * i));
      fetch(64'(4 * i), lat, d);
      checks++; if (lat != exp_lat) begin errors++; $display("FAIL hit_latency addr=%h got=%0d want=%0d", 4 * i, lat, exp_lat); end
      checks++; if (d !== rom_word(64'(4 * i))) begin errors++; $display("FAIL hit_data addr=%h got=%h want=%h", 4 * i, d, rom_word(64'(4 * i))); end
    end
    checks++; if (bus.perf_hits !== 32'd4) begin errors++; $display("FAIL hit_count got=%0d want=4", bus.perf_hits); end
  endtask

  task automatic test_conflict();
    logic [63:0] seq [3];
    int lat, exp_lat;
    logic [31:0] d;
    seq[0] = 64'h0; seq[1] = 64'h400; seq[2] = 64'h0;
    for (int i = 0; i < 3; i++) begin
      exp_lat = model_fetch(seq[i]);
      fetch(seq[i], lat, d);
      checks++; if (lat != exp_lat) begin errors++; $display("FAIL conflict_latency step=%0d got=%0d want=%0d", i, lat, exp_lat); end
      checks++; if (d !== rom_word(seq[i])) begin errors++; $display("FAIL conflict_data step=%0d got=%h want=%h", i, d, rom_word(seq[i])); end
    end
    checks++; if (bus.perf_misses !== 32'd3) begin errors++; $display("FAIL conflict_misses got=%0d want=3", bus.perf_misses); end
  endtask

  task automatic test_flush();
    int lat, exp_lat, rdy_seen;
    logic [31:0] d, h0;
    // Flush in refill cycle 2 of a miss on 0x40.
    bus.if_req = 1'b1; bus.if_addr = 64'h40;
    rdy_seen = 0;
    for (int cyc = 0; cyc < 3; cyc++) begin
      @(negedge clk); if (bus.if_ready) rdy_seen++;
      @(posedge clk); #1;
    end
    bus.flush = 1'b1;
    h0 = bus.perf_hits;
    @(negedge clk); if (bus.if_ready) rdy_seen++;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    m_count_miss();
    m_flush();
    checks++; if (rdy_seen != 0) begin errors++; $display("FAIL flush_refill_ready got=%0d want=0 ready cycles", rdy_seen); end
    checks++; if (bus.perf_misses !== m_misses) begin errors++; $display("FAIL flush_refill_misses got=%0d want=%0d", bus.perf_misses, m_misses); end
    checks++; if (bus.perf_hits !== h0) begin errors++; $display("FAIL flush_refill_hits got=%0d want=%0d", bus.perf_hits, h0); end
    exp_lat = model_fetch(64'h40);
    fetch(64'h40, lat, d);
    checks++; if (lat != exp_lat) begin errors++; $display("FAIL flush_refetch_latency got=%0d want=%0d", lat, exp_lat); end
    checks++; if (d !== rom_word(64'h40)) begin errors++; $display("FAIL flush_refetch_data got=%h want=%h", d, rom_word(64'h40)); end
    // Flush alongside a miss: no refill may start.
    bus.if_req = 1'b1; bus.if_addr = 64'h80; bus.flush = 1'b1;
    @(negedge clk);
    checks++; if (bus.if_ready !== 1'b0) begin errors++; $display("FAIL flush_miss_ready got=%b want=0", bus.if_ready); end
    @(posedge clk); #1;
    bus.flush = 1'b0;
    m_flush();
    checks++; if (bus.perf_misses !== m_misses) begin errors++; $display("FAIL flush_miss_count got=%0d want=%0d", bus.perf_misses, m_misses); end
    exp_lat = model_fetch(64'h80);
    fetch(64'h80, lat, d);
    checks++; if (lat != exp_lat) begin errors++; $display("FAIL flush_miss_latency got=%0d want=%0d", lat, exp_lat); end
    // Flush alongside a would-be hit: suppressed, not counted, line gone afterwards.
    bus.if_req = 1'b1; bus.if_addr = 64'h84; bus.flush = 1'b1;
    h0 = bus.perf_hits;
    @(negedge clk);
    checks++; if (bus.if_ready !== 1'b0) begin errors++; $display("FAIL flush_hit_ready got=%b want=0", bus.if_ready); end
    @(posedge clk); #1;
    bus.flush = 1'b0;
    m_flush();
    checks++; if (bus.perf_hits !== h0) begin errors++; $display("FAIL flush_hit_count got=%0d want=%0d", bus.perf_hits, h0); end
    exp_lat = model_fetch(64'h84);
    fetch(64'h84, lat, d);
    checks++; if (lat != exp_lat) begin errors++; $display("FAIL flush_hit_refetch got=%0d want=%0d", lat, exp_lat); end
  endtask

  task automatic test_random();
    int lat, exp_lat, tsel, gap;
    logic [63:0] a, base;
    logic [31:0] d;
    for (int n = 0; n < 150; n++) begin
      tsel = $urandom_range(0, 3);
      base = (tsel == 3) ? 64'hFFFF_FFF0_0000_0000 : 64'(tsel) << 10;
      a = base | (64'($urandom_range(0, 7)) << 4) | (64'($urandom_range(0, 3)) << 2) | 64'($urandom_range(0, 3));
      gap = $urandom_range(0, 2);
      bus.if_addr = {$urandom, $urandom};
      repeat (gap) begin @(posedge clk); #1; end
      exp_lat = model_fetch(a);
      fetch(a, lat, d);
      checks++; if (lat != exp_lat) begin errors++; $display("FAIL rand_latency n=%0d addr=%h got=%0d want=%0d", n, a, lat, exp_lat); end
      checks++; if (d !== rom_word(a)) begin errors++; $display("FAIL rand_data n=%0d addr=%h got=%h want=%h", n, a, d, rom_word(a)); end
    end
    checks++; if (bus.perf_hits !== m_hits) begin errors++; $display("FAIL rand_hits got=%0d want=%0d", bus.perf_hits, m_hits); end
    checks++; if (bus.perf_misses !== m_misses) begin errors++; $display("FAIL rand_misses got=%0d want=%0d", bus.perf_misses, m_misses); end
  endtask

  task automatic test_async_reset();
    int lat, exp_lat;
    logic [31:0] d;
    bus.if_req = 1'b1; bus.if_addr = 64'h10;
    m_flush();
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.if_ready !== 1'b0) begin errors++; $display("FAIL areset_ready got=%b want=0", bus.if_ready); end
    checks++; if (bus.perf_hits !== 32'h0 || bus.perf_misses !== 32'h0) begin errors++; $display("FAIL areset_counters got=%0d/%0d want=0/0", bus.perf_hits, bus.perf_misses); end
    checks++; if (bus.rom_addr !== 64'h0) begin errors++; $display("FAIL areset_rom_addr got=%h want=0", bus.rom_addr); end
    bus.if_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    m_reset();
    @(posedge clk); #1;
    exp_lat = model_fetch(64'h10);
    fetch(64'h10, lat, d);
    checks++; if (lat != exp_lat) begin errors++; $display("FAIL areset_refetch got=%0d want=%0d", lat, exp_lat); end
    checks++; if (bus.perf_misses !== 32'd1) begin errors++; $display("FAIL areset_misses got=%0d want=1", bus.perf_misses); end
  endtask

  task automatic test_saturation();
    int lat, exp_lat;
    logic [31:0] d;
    @(negedge clk);
    force dut.hit_cnt = 32'hFFFF_FFFE;
    #1 release dut.hit_cnt;
    m_hits = 32'hFFFF_FFFE;
    for (int i = 0; i < 3; i++) begin
      exp_lat = model_fetch(64'h10 + 64'(4 * i));
      fetch(64'h10 + 64'(4 * i), lat, d);
      checks++; if (lat != exp_lat) begin errors++; $display("FAIL sat_latency step=%0d got=%0d want=%0d", i, lat, exp_lat); end
      checks++; if (bus.perf_hits !== m_hits) begin errors++; $display("FAIL sat_hits step=%0d got=%h want=%h", i, bus.perf_hits, m_hits); end
    end
  endtask

  initial begin
    bus.if_req  = 1'b0;
    bus.if_addr = '0;
    bus.flush   = 1'b0;
    rst         = 1'b1;
    test_reset();
    test_first_miss();
    test_line_hits();
    test_conflict();
    test_flush();
    test_random();
    test_async_reset();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time exceeded");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/icache_dm.md
Name: icache_dm

Overview:
- Direct-mapped, read-only instruction cache between the data_path fetch port (rom_addr/rom_dout) and the synchronous instruction ROM.
- Hits return the instruction in the cycle of the request.
- Misses stall fetch via if_ready while a line-refill FSM streams the line from ROM.
- Also provides fence.i flush and saturating hit/miss performance counters.

Parameters:
- LINE_WORDS, 4: 32-bit words per line; power of two, >=2.
- NUM_LINES, 64: number of lines; power of two.
- ROM_LATENCY, 1: cycles from rom_addr to valid rom_dout; supported values 1..2.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- if_req  input  1  fetch request valid.
- if_addr  input  64  fetch byte address; bits [1:0] ignored.
- if_dout  output  32  instruction; valid only when if_ready=1.
- if_ready  output  1  hit/return strobe for the current if_addr.
- flush  input  1  invalidate all lines (fence.i).
- rom_addr  output  64  ROM byte address, word aligned.
- rom_dout  input  32  ROM read data, valid ROM_LATENCY cycles after rom_addr.
- perf_hits  output  32  saturating hit count.
- perf_misses  output  32  saturating miss count.

Behaviour:

Address split (defaults):
- offset = if_addr[3:2]
- index = if_addr[9:4]
- tag = if_addr[63:10]
- General case: offset width log2(LINE_WORDS), index width log2(NUM_LINES), tag is the remainder.

Storage:
- valid[NUM_LINES], tag[NUM_LINES], data[NUM_LINES][LINE_WORDS].
- Only valid is reset. Tag and data are not reset.

Reset (async, while rst=1):
- state=IDLE, all valid=0, refill counter=0.
- if_ready=0, if_dout=0.
- perf_hits=0, perf_misses=0.
- rom_addr=0.

Hit:
- hit = valid[index] && tag[index]==tag(if_addr).
- if_ready = (state==IDLE) && if_req && hit && !flush. This is combinational, zero-cycle latency.
- if_dout = data[index][offset] when if_ready; otherwise 0.

FSM states: IDLE, REFILL.

IDLE:
- rom_addr = {if_addr[63:2],2'b00}.
- If if_req && !hit && !flush:
  - latch line_base = if_addr with offset and [1:0] cleared.
  - clear valid[index] and write tag[index].
  - cnt=0, go to REFILL, perf_misses++.
- If if_req && hit && !flush: perf_hits++.

REFILL:
- The state lasts LINE_WORDS+ROM_LATENCY cycles.
- On refill cycle c (0-based), rom_addr = line_base + 4*c for c<LINE_WORDS. For c>=LINE_WORDS, rom_addr holds the last word address.
- On cycle c>=ROM_LATENCY, write rom_dout into data[idx][c-ROM_LATENCY].
- After the final write: set valid[idx]=1 and return to IDLE.
- if_ready=0 throughout REFILL.

Miss latency:
- Defaults: miss seen in cycle 0, REFILL in cycles 1..5, hit with if_ready=1 in cycle 6.
- In general the miss penalty is LINE_WORDS+ROM_LATENCY+1 cycles.

Requester rule and address changes:
- The requester holds if_addr stable while if_req && !if_ready.
- If if_addr changes during REFILL, the refill still completes for the latched line. The new address is looked up in IDLE afterwards.
- if_req deasserting mid-refill does not abort the refill.

Flush:
- Single cycle; clears all valid bits on the next edge.
- In REFILL: abort, return to IDLE, the line stays invalid.
- In the flush cycle: if_ready=0 and counters are unchanged.
- flush and a miss in the same IDLE cycle: flush wins and no refill starts.

Counters:
- Saturate at 32'hFFFF_FFFF; no wrap.
- At most one increments per cycle.

Index conflict:
- A miss on index i evicts the line held there; there is no write-back (read-only cache).

Test Plan:
1. Reset, then if_req=1, if_addr=0x0. Cycle 0 if_ready=0, rom_addr=0x0,0x4,0x8,0xC in cycles 1–4. Cycle 6: if_ready=1, if_dout=ROM[0]. perf_misses=1.
2. After scenario 1, fetch 0x4, 0x8, 0xC on consecutive cycles: if_ready=1 each cycle with the matching ROM words. perf_hits=4 (including the cycle-6 hit).
3. Fetch 0x0, then 0x400 (same index 0, different tag): miss, refill from 0x400. Refetch 0x0: miss again. perf_misses=3.
4. Assert flush in refill cycle 2 of a miss on 0x40: FSM returns to IDLE and if_ready stays 0. The next request to 0x40 misses and performs a full refill with correct data.
5. Fetch 0x10, assert rst asynchronously mid-REFILL: if_ready=0 and counters=0 immediately. After release, 0x10 misses.
6. Preload perf_hits near saturation (force 32'hFFFF_FFFE), issue 3 hits: perf_hits stays 32'hFFFF_FFFF.
